// File: rtl/vc_input_ctrl_pkg.sv
// Shared NoC types for the router input port: flit format, port ids, VC controller states.
package noc_params;

    localparam int VC_NUM   = 2;
    localparam int PORT_NUM = 5;
    localparam int VC_W     = $clog2(VC_NUM);
    localparam int PORT_W   = $clog2(PORT_NUM);
    localparam int DEST_W   = 4;
    localparam int DATA_W   = 16;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef enum logic [PORT_W-1:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

    typedef struct packed {
        flit_label_t         label;
        logic [VC_W-1:0]     vc_id;
        logic [DEST_W-1:0]   dest;
        logic [DATA_W-1:0]   data;
    } flit_t;

    typedef enum logic [1:0] {IDLE, VA, SA} vc_ctrl_state_t;

    function automatic logic is_head(flit_label_t l);
        return (l == HEAD) || (l == HEADTAIL);
    endfunction

    function automatic logic is_tail(flit_label_t l);
        return (l == TAIL) || (l == HEADTAIL);
    endfunction

endpackage

// File: rtl/vc_input_ctrl.sv
// Per-VC packet controller: route latch, VC allocation, per-flit switch allocation and FIFO pop.
// Optional macro VC_INPUT_CTRL_ERR_EN enables the sticky protocol-error flag and stray-flit drop.
module vc_input_ctrl
    import noc_params::*;
(
    input  logic             clk,
    input  logic             rst,
    input  flit_t            flit_i,
    input  logic             empty_i,
    output logic             read_o,
    input  port_t            out_port_i,
    output logic             va_req_o,
    output port_t            va_port_o,
    input  logic             va_grant_i,
    input  logic [VC_W-1:0]  va_vc_i,
    input  logic             on_off_i,
    output logic             sa_req_o,
    output port_t            sa_port_o,
    input  logic             sa_grant_i,
    output flit_t            flit_o,
    output logic             valid_o,
    output logic             err_o
);

    vc_ctrl_state_t   r_state;
    vc_ctrl_state_t   w_state_nxt;
    port_t            r_port;
    logic [VC_W-1:0]  r_vc;
    flit_t            r_flit;
    logic             r_valid;

    logic             w_head_seen;
    logic             w_sa_req;
    logic             w_sa_fire;

    assign w_head_seen = (r_state == IDLE) && !empty_i && is_head(flit_i.label);
    assign w_sa_req    = (r_state == SA) && !empty_i && on_off_i;
    assign w_sa_fire   = w_sa_req && sa_grant_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_head_seen) w_state_nxt = VA;
            VA:      if (va_grant_i) w_state_nxt = SA;
            SA:      if (w_sa_fire && is_tail(flit_i.label)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_port  <= LOCAL;
            r_vc    <= '0;
            r_flit  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_sa_fire;
            if (w_head_seen) begin
                r_port <= out_port_i;
            end
            if ((r_state == VA) && va_grant_i) begin
                r_vc <= va_vc_i;
            end
            // Flit leaves restamped with the downstream VC won in allocation.
            if (w_sa_fire) begin
                r_flit       <= flit_i;
                r_flit.vc_id <= r_vc;
            end
        end
    end

`ifdef VC_INPUT_CTRL_ERR_EN
    logic r_err;
    logic w_stray;
    logic w_err_evt;

    // Gated by rst so the reset pulse itself never pops the FIFO.
    assign w_stray   = !rst && (r_state == IDLE) && !empty_i && !is_head(flit_i.label);
    assign w_err_evt = w_stray
                     || (w_sa_fire && is_head(flit_i.label))
                     || (va_grant_i && (r_state != VA));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign read_o = w_sa_fire || w_stray;
    assign err_o  = r_err;
`else
    assign read_o = w_sa_fire;
    assign err_o  = 1'b0;
`endif

    assign va_req_o  = (r_state == VA);
    assign va_port_o = r_port;
    assign sa_req_o  = w_sa_req;
    assign sa_port_o = r_port;
    assign flit_o    = r_flit;
    assign valid_o   = r_valid;

endmodule

// File: tb/tb_vc_input_ctrl.sv
// Self-checking bench for vc_input_ctrl: cycle table, directed corner sequences, random packet traffic.
module tb_vc_input_ctrl;
    import noc_params::*;

    logic             clk = 1'b0;
    logic             rst;
    flit_t            flit_i;
    logic             empty_i;
    logic             read_o;
    port_t            out_port_i;
    logic             va_req_o;
    port_t            va_port_o;
    logic             va_grant_i;
    logic [VC_W-1:0]  va_vc_i;
    logic             on_off_i;
    logic             sa_req_o;
    port_t            sa_port_o;
    logic             sa_grant_i;
    flit_t            flit_o;
    logic             valid_o;
    logic             err_o;

    vc_input_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .flit_i     (flit_i),
        .empty_i    (empty_i),
        .read_o     (read_o),
        .out_port_i (out_port_i),
        .va_req_o   (va_req_o),
        .va_port_o  (va_port_o),
        .va_grant_i (va_grant_i),
        .va_vc_i    (va_vc_i),
        .on_off_i   (on_off_i),
        .sa_req_o   (sa_req_o),
        .sa_port_o  (sa_port_o),
        .sa_grant_i (sa_grant_i),
        .flit_o     (flit_o),
        .valid_o    (valid_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " read_o"},   32'(read_o),    32'd0);
        chk({tag, " va_req_o"}, 32'(va_req_o),  32'd0);
        chk({tag, " va_port"},  32'(va_port_o), 32'd0);
        chk({tag, " sa_req_o"}, 32'(sa_req_o),  32'd0);
        chk({tag, " sa_port"},  32'(sa_port_o), 32'd0);
        chk({tag, " flit_o"},   32'(flit_o),    32'd0);
        chk({tag, " valid_o"},  32'(valid_o),   32'd0);
        chk({tag, " err_o"},    32'(err_o),     32'd0);
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        bit               empty;
        flit_label_t      lab;
        port_t            port;
        bit               vag;
        logic [VC_W-1:0]  vavc;
        bit               onoff;
        bit               sag;
        bit               e_read;
        bit               e_vareq;
        bit               e_sareq;
        port_t            e_port;
        bit               e_valid;
        logic [VC_W-1:0]  e_vcid;
    } vec_t;

    function automatic vec_t mk(input int e, input flit_label_t l, input port_t p, input int vag,
                                input int vc, input int onoff, input int sag, input int rd,
                                input int vr, input int sr, input port_t ep, input int ev,
                                input int evc);
        vec_t v;
        v.empty = (e != 0);   v.lab = l;            v.port = p;
        v.vag = (vag != 0);   v.vavc = VC_W'(vc);   v.onoff = (onoff != 0);
        v.sag = (sag != 0);   v.e_read = (rd != 0); v.e_vareq = (vr != 0);
        v.e_sareq = (sr != 0); v.e_port = ep;       v.e_valid = (ev != 0);
        v.e_vcid = VC_W'(evc);
        return v;
    endfunction

    vec_t tbl[21];

    // ---------------- reference model ----------------
    flit_t            fifo[$];
    bit               m_busy, m_hv, m_valid, m_err;
    port_t            m_port;
    logic [VC_W-1:0]  m_vc;
    flit_t            m_flit;

    bit               k_vag, k_onoff, k_sag;
    logic [VC_W-1:0]  k_vavc;
    port_t            k_port;

    function automatic bit lab_head(flit_label_t l);
        return (l == HEAD) || (l == HEADTAIL);
    endfunction
    function automatic bit lab_tail(flit_label_t l);
        return (l == TAIL) || (l == HEADTAIL);
    endfunction

    task automatic model_clear();
        m_busy = 0; m_hv = 0; m_valid = 0; m_err = 0;
        m_port = LOCAL; m_vc = '0; m_flit = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        empty_i = 1'b1; flit_i = '0; out_port_i = LOCAL;
        va_grant_i = 1'b0; va_vc_i = '0; on_off_i = 1'b0; sa_grant_i = 1'b0;
        k_vag = 0; k_vavc = '0; k_onoff = 0; k_sag = 0; k_port = LOCAL;
        fifo.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic step();
        bit emp, e_vareq, e_sareq, e_read, fire, stray;
        logic [31:0] rnd;
        flit_t f;
        @(negedge clk);
        emp = (fifo.size() == 0);
        rnd = $urandom;
        f = emp ? flit_t'(rnd[$bits(flit_t)-1:0]) : fifo[0];
        flit_i = f; empty_i = emp; out_port_i = k_port;
        va_grant_i = k_vag; va_vc_i = k_vavc; on_off_i = k_onoff; sa_grant_i = k_sag;
        #1;
        e_vareq = m_busy && !m_hv;
        e_sareq = m_hv && !emp && k_onoff;
        fire    = e_sareq && k_sag;
        stray   = !m_busy && !emp && !lab_head(f.label);
        e_read  = fire;
`ifdef VC_INPUT_CTRL_ERR_EN
        if (stray) e_read = 1;
`endif
        chk("rnd read_o",   32'(read_o),    32'(e_read));
        chk("rnd va_req_o", 32'(va_req_o),  32'(e_vareq));
        chk("rnd sa_req_o", 32'(sa_req_o),  32'(e_sareq));
        chk("rnd va_port",  32'(va_port_o), 32'(m_port));
        chk("rnd sa_port",  32'(sa_port_o), 32'(m_port));
        chk("rnd valid_o",  32'(valid_o),   32'(m_valid));
        chk("rnd err_o",    32'(err_o),     32'(m_err));
        if (m_valid) chk("rnd flit_o", 32'(flit_o), 32'(m_flit));
`ifdef VC_INPUT_CTRL_ERR_EN
        if (stray || (fire && lab_head(f.label)) || (k_vag && !e_vareq)) m_err = 1;
`endif
        m_valid = fire;
        if (fire) begin
            m_flit = f;
            m_flit.vc_id = m_vc;
        end
        if (!m_busy) begin
            if (!emp && lab_head(f.label)) begin
                m_busy = 1; m_hv = 0; m_port = k_port;
            end
        end else if (!m_hv) begin
            if (k_vag) begin
                m_hv = 1; m_vc = k_vavc;
            end
        end else if (fire && lab_tail(f.label)) begin
            m_busy = 0; m_hv = 0;
        end
        if (e_read) void'(fifo.pop_front());
    endtask

    function automatic flit_t mkflit(input flit_label_t l);
        flit_t f;
        f.label = l;
        f.vc_id = VC_W'($urandom);
        f.dest  = DEST_W'($urandom);
        f.data  = DATA_W'($urandom);
        return f;
    endfunction

    int g_left = 0;

    initial begin
        // reset state
        rst = 1'b1;
        empty_i = 1'b1; flit_i = '0; out_port_i = LOCAL;
        va_grant_i = 1'b0; va_vc_i = '0; on_off_i = 1'b0; sa_grant_i = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_zero("reset");
        do_reset();

        // HEAD/BODY/TAIL, then HEADTAIL to EAST, then back-to-back packets (WEST then NORTH)
        tbl[0]  = mk(0, HEAD,     SOUTH, 0,0,1,1, 0,0,0, LOCAL, 0,0);
        tbl[1]  = mk(0, HEAD,     SOUTH, 1,1,1,1, 0,1,0, SOUTH, 0,0);
        tbl[2]  = mk(0, HEAD,     LOCAL, 0,0,1,1, 1,0,1, SOUTH, 0,0);
        tbl[3]  = mk(0, BODY,     LOCAL, 0,0,1,1, 1,0,1, SOUTH, 1,1);
        tbl[4]  = mk(0, TAIL,     LOCAL, 0,0,1,1, 1,0,1, SOUTH, 1,1);
        tbl[5]  = mk(1, BODY,     LOCAL, 0,0,1,1, 0,0,0, SOUTH, 1,1);
        tbl[6]  = mk(1, HEAD,     LOCAL, 0,0,1,1, 0,0,0, SOUTH, 0,0);
        tbl[7]  = mk(0, HEADTAIL, EAST,  0,0,1,0, 0,0,0, SOUTH, 0,0);
        tbl[8]  = mk(0, HEADTAIL, WEST,  1,0,1,0, 0,1,0, EAST,  0,0);
        tbl[9]  = mk(0, HEADTAIL, WEST,  0,0,1,1, 1,0,1, EAST,  0,0);
        tbl[10] = mk(1, HEADTAIL, WEST,  0,0,1,1, 0,0,0, EAST,  1,0);
        tbl[11] = mk(0, HEAD,     WEST,  0,0,1,1, 0,0,0, EAST,  0,0);
        tbl[12] = mk(0, HEAD,     LOCAL, 1,1,1,1, 0,1,0, WEST,  0,0);
        tbl[13] = mk(0, HEAD,     LOCAL, 0,0,1,1, 1,0,1, WEST,  0,0);
        tbl[14] = mk(0, TAIL,     LOCAL, 0,0,1,1, 1,0,1, WEST,  1,1);
        tbl[15] = mk(0, HEADTAIL, NORTH, 0,0,1,1, 0,0,0, WEST,  1,1);
        tbl[16] = mk(0, HEADTAIL, LOCAL, 0,0,1,1, 0,1,0, NORTH, 0,0);
        tbl[17] = mk(0, HEADTAIL, LOCAL, 1,0,1,1, 0,1,0, NORTH, 0,0);
        tbl[18] = mk(0, HEADTAIL, LOCAL, 0,0,1,0, 0,0,1, NORTH, 0,0);
        tbl[19] = mk(0, HEADTAIL, LOCAL, 0,0,1,1, 1,0,1, NORTH, 0,0);
        tbl[20] = mk(1, HEAD,     LOCAL, 0,0,0,0, 0,0,0, NORTH, 1,0);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            flit_i = mkflit(tbl[i].lab);
            empty_i = tbl[i].empty; out_port_i = tbl[i].port;
            va_grant_i = tbl[i].vag; va_vc_i = tbl[i].vavc;
            on_off_i = tbl[i].onoff; sa_grant_i = tbl[i].sag;
            #1;
            chk("tbl read_o",   32'(read_o),    32'(tbl[i].e_read));
            chk("tbl va_req_o", 32'(va_req_o),  32'(tbl[i].e_vareq));
            chk("tbl sa_req_o", 32'(sa_req_o),  32'(tbl[i].e_sareq));
            chk("tbl va_port",  32'(va_port_o), 32'(tbl[i].e_port));
            chk("tbl sa_port",  32'(sa_port_o), 32'(tbl[i].e_port));
            chk("tbl valid_o",  32'(valid_o),   32'(tbl[i].e_valid));
            chk("tbl err_o",    32'(err_o),     32'd0);
            if (tbl[i].e_valid) chk("tbl vc_id", 32'(flit_o.vc_id), 32'(tbl[i].e_vcid));
        end

        // on_off low in SA with grant held: stall, then resume
        do_reset();
        fifo.push_back(mkflit(HEAD)); fifo.push_back(mkflit(BODY)); fifo.push_back(mkflit(TAIL));
        k_onoff = 1; k_sag = 1; k_port = SOUTH;
        step();
        k_vag = 1; k_vavc = 1;
        step();
        k_vag = 0;
        step();
        k_onoff = 0;
        repeat (4) step();
        k_onoff = 1;
        repeat (4) step();

        // FIFO runs dry after BODY, TAIL arrives three cycles later
        do_reset();
        fifo.push_back(mkflit(HEAD)); fifo.push_back(mkflit(BODY));
        k_onoff = 1; k_sag = 1; k_port = WEST;
        step();
        k_vag = 1; k_vavc = 0;
        step();
        k_vag = 0;
        repeat (5) step();
        fifo.push_back(mkflit(TAIL));
        repeat (3) step();

        // reset mid-packet with a BODY flit left at the head
        do_reset();
        fifo.push_back(mkflit(HEAD)); fifo.push_back(mkflit(BODY));
        fifo.push_back(mkflit(BODY)); fifo.push_back(mkflit(TAIL));
        k_onoff = 1; k_sag = 1; k_port = NORTH;
        step();
        k_vag = 1; k_vavc = 1;
        step();
        k_vag = 0;
        step();
        k_sag = 0;
        step();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("midrst");
        empty_i = 1'b1;
        #1 rst = 1'b0;
        model_clear();
        k_sag = 1;
        repeat (4) step();
        chk("midrst fifo depth", 32'(fifo.size()),
`ifdef VC_INPUT_CTRL_ERR_EN
            32'd0
`else
            32'd3
`endif
        );

        // random legal packet traffic
        do_reset();
        g_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (fifo.size() < 4 && ($urandom % 3) != 0) begin
                if (g_left == 0) begin
                    g_left = $urandom_range(1, 4);
                    fifo.push_back(mkflit(g_left == 1 ? HEADTAIL : HEAD));
                    g_left--;
                end else begin
                    g_left--;
                    fifo.push_back(mkflit(g_left == 0 ? TAIL : BODY));
                end
            end
            k_port  = port_t'($urandom_range(0, 4));
            k_vavc  = VC_W'($urandom);
            k_onoff = ($urandom % 4) != 0;
            k_sag   = ($urandom % 3) != 0;
            k_vag   = (m_busy && !m_hv) ? ($urandom % 2 == 1) : ($urandom % 64 == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
